// File: rtl/mem_stage_ctrl_if.sv
// Bundle of EX/MEM inputs, data-memory req/ack port, stall/branch outputs and MEM/WB register.
// The master modport is the MEM-stage controller; the slave modport is the surrounding pipe/memory.
interface mem_stage_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DST_W  = 5
);
  logic [DATA_W-1:0] ext_pc;
  logic [DATA_W-1:0] aluresult;
  logic              zero;
  logic [DATA_W-1:0] rt;
  logic [DST_W-1:0]  swdst;
  logic              branch;
  logic              memread;
  logic              memwrite;
  logic              regwrite;
  logic [1:0]        memtoreg;

  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_stall;
  logic              pcsrc;
  logic [DATA_W-1:0] branch_target;

  logic              wb_regwrite;
  logic [1:0]        wb_memtoreg;
  logic [DST_W-1:0]  wb_dst;
  logic [DATA_W-1:0] wb_aluresult;
  logic [DATA_W-1:0] wb_memdata;
  logic [DATA_W-1:0] wb_pc;
  logic              dm_err;

  modport master (
    input  ext_pc, aluresult, zero, rt, swdst, branch, memread, memwrite, regwrite, memtoreg,
    input  dm_ack, dm_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_stall, pcsrc, branch_target,
    output wb_regwrite, wb_memtoreg, wb_dst, wb_aluresult, wb_memdata, wb_pc, dm_err
  );

  modport slave (
    output ext_pc, aluresult, zero, rt, swdst, branch, memread, memwrite, regwrite, memtoreg,
    output dm_ack, dm_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_stall, pcsrc, branch_target,
    input  wb_regwrite, wb_memtoreg, wb_dst, wb_aluresult, wb_memdata, wb_pc, dm_err
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: req/ack data-memory FSM, stall generation, branch resolve, MEM/WB register.
// Optional macro MEM_TIMEOUT_EN adds a BUSY timeout that aborts the access and sets sticky dm_err.
module mem_stage_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DST_W   = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_ctrl_if.master bus
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be >= 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_acc;
  logic w_req;
  logic w_ack;
  logic w_abort;
  logic w_stall;
  logic w_rd_ack;

  logic              r_wb_regwrite;
  logic [1:0]        r_wb_memtoreg;
  logic [DST_W-1:0]  r_wb_dst;
  logic [DATA_W-1:0] r_wb_aluresult;
  logic [DATA_W-1:0] r_wb_memdata;
  logic [DATA_W-1:0] r_wb_pc;

  assign w_acc = bus.memread | bus.memwrite;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Terminal BUSY cycle without ack: release stall now, drop request from the next cycle.
  assign w_abort = (r_state == BUSY) && (r_cnt == CNT_W'(TIMEOUT - 1)) && !bus.dm_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == IDLE) ? '0 : r_cnt + CNT_W'(1);
      if (w_abort) r_err <= 1'b1;
    end
  end

  assign bus.dm_err = r_err;
`else
  assign w_abort    = 1'b0;
  assign bus.dm_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      IDLE: begin
        w_req = w_acc;
        if (w_acc && !bus.dm_ack) w_state_nxt = BUSY;
      end
      BUSY: begin
        w_req = 1'b1;
        if (bus.dm_ack || w_abort) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Request must vanish the moment reset is asserted, not at the next edge.
    if (rst) w_req = 1'b0;
  end

  assign w_ack    = w_req & bus.dm_ack;
  assign w_stall  = w_req & ~bus.dm_ack & ~w_abort;
  assign w_rd_ack = w_ack & bus.memread & ~bus.memwrite;

  // MEM/WB register: bubble on stall or abort, otherwise capture the retiring instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= '0;
      r_wb_dst       <= '0;
      r_wb_aluresult <= '0;
      r_wb_memdata   <= '0;
      r_wb_pc        <= '0;
    end else if (w_stall || w_abort) begin
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= '0;
      r_wb_dst       <= '0;
      r_wb_aluresult <= '0;
      r_wb_memdata   <= '0;
      r_wb_pc        <= '0;
    end else begin
      r_wb_regwrite  <= bus.regwrite;
      r_wb_memtoreg  <= bus.memtoreg;
      r_wb_dst       <= bus.swdst;
      r_wb_aluresult <= bus.aluresult;
      r_wb_memdata   <= w_rd_ack ? bus.dm_rdata : '0;
      r_wb_pc        <= bus.ext_pc;
    end
  end

  assign bus.dm_req        = w_req;
  assign bus.dm_we         = bus.memwrite;
  assign bus.dm_addr       = bus.aluresult;
  assign bus.dm_wdata      = bus.rt;
  assign bus.mem_stall     = w_stall;
  assign bus.pcsrc         = bus.branch & bus.zero;
  assign bus.branch_target = bus.ext_pc;

  assign bus.wb_regwrite   = r_wb_regwrite;
  assign bus.wb_memtoreg   = r_wb_memtoreg;
  assign bus.wb_dst        = r_wb_dst;
  assign bus.wb_aluresult  = r_wb_aluresult;
  assign bus.wb_memdata    = r_wb_memdata;
  assign bus.wb_pc         = r_wb_pc;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: expected MEM/WB records are queued by the stimulus and
// checked by a separate negedge monitor; combinational outputs are checked inline.
module tb_mem_stage_ctrl;

  typedef struct packed {
    logic        rw;
    logic [1:0]  mtr;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] md;
    logic [31:0] pc;
  } wb_t;

  logic clk;
  logic rst;
  logic mon_en;
  int   tests;
  int   fails;
  wb_t  exp_q[$];
  wb_t  mon_got;
  wb_t  mon_exp;

  mem_stage_ctrl_if #(.DATA_W(32), .DST_W(5)) bus ();

  mem_stage_ctrl #(.DATA_W(32), .DST_W(5), .TIMEOUT(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic rw, input logic [1:0] mtr, input logic [4:0] dst,
                      input logic [31:0] alu, input logic [31:0] md, input logic [31:0] pc);
    wb_t e;
    e.rw = rw; e.mtr = mtr; e.dst = dst; e.alu = alu; e.md = md; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rtv,
                           input logic [4:0] dst, input logic br, input logic z,
                           input logic mr, input logic mw, input logic rw, input logic [1:0] mtr);
    bus.ext_pc    = pc;
    bus.aluresult = alu;
    bus.rt        = rtv;
    bus.swdst     = dst;
    bus.branch    = br;
    bus.zero      = z;
    bus.memread   = mr;
    bus.memwrite  = mw;
    bus.regwrite  = rw;
    bus.memtoreg  = mtr;
  endtask

  task automatic nop();
    set_instr(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic mem_resp(input logic ack, input logic [31:0] rdata);
    bus.dm_ack   = ack;
    bus.dm_rdata = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every non-bubble MEM/WB content must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      mon_got.rw  = bus.wb_regwrite;
      mon_got.mtr = bus.wb_memtoreg;
      mon_got.dst = bus.wb_dst;
      mon_got.alu = bus.wb_aluresult;
      mon_got.md  = bus.wb_memdata;
      mon_got.pc  = bus.wb_pc;
      if (mon_got != '0) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL wb_unexpected: got rw=%0b mtr=%0b dst=%0d alu=0x%0h md=0x%0h pc=0x%0h expected bubble",
                   mon_got.rw, mon_got.mtr, mon_got.dst, mon_got.alu, mon_got.md, mon_got.pc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            fails++;
            $display("FAIL wb_record: got rw=%0b mtr=%0b dst=%0d alu=0x%0h md=0x%0h pc=0x%0h expected rw=%0b mtr=%0b dst=%0d alu=0x%0h md=0x%0h pc=0x%0h",
                     mon_got.rw, mon_got.mtr, mon_got.dst, mon_got.alu, mon_got.md, mon_got.pc,
                     mon_exp.rw, mon_exp.mtr, mon_exp.dst, mon_exp.alu, mon_exp.md, mon_exp.pc);
          end
        end
      end
    end
  end

  initial begin
    tests  = 0;
    fails  = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    nop();
    mem_resp(1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_dm_req", 32'(bus.dm_req), 32'h0);
    chk("rst_stall", 32'(bus.mem_stall), 32'h0);
    chk("rst_wb_regwrite", 32'(bus.wb_regwrite), 32'h0);
    chk("rst_wb_alu", bus.wb_aluresult, 32'h0);
    chk("rst_dm_err", 32'(bus.dm_err), 32'h0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Read acked in the same cycle: no stall, writeback next edge.
    tick();
    set_instr(32'h100, 32'h10, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    mem_resp(1'b1, 32'hDEADBEEF);
    #1;
    chk("t1_dm_req", 32'(bus.dm_req), 32'h1);
    chk("t1_dm_we", 32'(bus.dm_we), 32'h0);
    chk("t1_dm_addr", bus.dm_addr, 32'h10);
    chk("t1_stall", 32'(bus.mem_stall), 32'h0);
    push(1'b1, 2'b01, 5'd8, 32'h10, 32'hDEADBEEF, 32'h100);
    tick();
    nop();
    mem_resp(1'b0, 32'h0);
    #1;
    chk("t1_wb_regwrite", 32'(bus.wb_regwrite), 32'h1);
    chk("t1_wb_dst", 32'(bus.wb_dst), 32'd8);
    chk("t1_wb_memdata", bus.wb_memdata, 32'hDEADBEEF);

    // Write acked after three stalled cycles.
    tick();
    set_instr(32'h104, 32'h20, 32'h55, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    #1;
    chk("t2_stall_c0", 32'(bus.mem_stall), 32'h1);
    chk("t2_we_c0", 32'(bus.dm_we), 32'h1);
    chk("t2_wdata", bus.dm_wdata, 32'h55);
    tick();
    #1;
    chk("t2_stall_c1", 32'(bus.mem_stall), 32'h1);
    chk("t2_bubble_rw", 32'(bus.wb_regwrite), 32'h0);
    chk("t2_bubble_alu", bus.wb_aluresult, 32'h0);
    tick();
    #1;
    chk("t2_stall_c2", 32'(bus.mem_stall), 32'h1);
    chk("t2_we_c2", 32'(bus.dm_we), 32'h1);
    tick();
    mem_resp(1'b1, 32'h0);
    #1;
    chk("t2_stall_ack", 32'(bus.mem_stall), 32'h0);
    chk("t2_req_ack", 32'(bus.dm_req), 32'h1);
    push(1'b0, 2'b00, 5'd3, 32'h20, 32'h0, 32'h104);
    tick();
    nop();
    mem_resp(1'b0, 32'h0);
    #1;
    chk("t2_wb_alu", bus.wb_aluresult, 32'h20);
    chk("t2_wb_regwrite", 32'(bus.wb_regwrite), 32'h0);

    // Branch resolve.
    tick();
    set_instr(32'h40, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    #1;
    chk("t3_pcsrc_taken", 32'(bus.pcsrc), 32'h1);
    chk("t3_target", bus.branch_target, 32'h40);
    chk("t3_no_req", 32'(bus.dm_req), 32'h0);
    chk("t3_no_stall", 32'(bus.mem_stall), 32'h0);
    push(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h40);
    tick();
    bus.zero = 1'b0;
    #1;
    chk("t3_pcsrc_not", 32'(bus.pcsrc), 32'h0);
    push(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h40);
    tick();
    nop();

    // Reset pulse while a read is pending; late ack afterwards is ignored.
    tick();
    set_instr(32'h108, 32'h30, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    #1;
    chk("t4_stall_idle", 32'(bus.mem_stall), 32'h1);
    tick();
    chk("t4_stall_busy", 32'(bus.mem_stall), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("t4_rst_req", 32'(bus.dm_req), 32'h0);
    chk("t4_rst_stall", 32'(bus.mem_stall), 32'h0);
    chk("t4_rst_wb_rw", 32'(bus.wb_regwrite), 32'h0);
    chk("t4_rst_wb_pc", bus.wb_pc, 32'h0);
    #1;
    rst = 1'b0;
    nop();
    mem_resp(1'b1, 32'h00000BAD);
    #1;
    chk("t4_post_req", 32'(bus.dm_req), 32'h0);
    chk("t4_post_stall", 32'(bus.mem_stall), 32'h0);
    tick();
    mem_resp(1'b0, 32'h0);
    #1;
    chk("t4_late_ack_md", bus.wb_memdata, 32'h0);
    chk("t4_late_ack_rw", 32'(bus.wb_regwrite), 32'h0);

    // Read that is never acknowledged.
    tick();
    set_instr(32'h10C, 32'h50, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    #1;
    chk("t5_stall_0", 32'(bus.mem_stall), 32'h1);
`ifdef MEM_TIMEOUT_EN
    for (int i = 1; i < 4; i++) begin
      tick();
      #1;
      chk("t5_stall_n", 32'(bus.mem_stall), 32'h1);
    end
    tick();
    #1;
    chk("t5_stall_released", 32'(bus.mem_stall), 32'h0);
    chk("t5_err_before", 32'(bus.dm_err), 32'h0);
    tick();
    nop();
    #1;
    chk("t5_err_set", 32'(bus.dm_err), 32'h1);
    chk("t5_req_dropped", 32'(bus.dm_req), 32'h0);
    chk("t5_bubble_rw", 32'(bus.wb_regwrite), 32'h0);
    tick();
    set_instr(32'h118, 32'h70, 32'h0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    mem_resp(1'b1, 32'h0BADF00D);
    #1;
    chk("t5_resume_stall", 32'(bus.mem_stall), 32'h0);
    push(1'b1, 2'b01, 5'd12, 32'h70, 32'h0BADF00D, 32'h118);
    tick();
    nop();
    mem_resp(1'b0, 32'h0);
`else
    for (int i = 1; i < 100; i++) begin
      tick();
      #1;
      chk("t5_stall_n", 32'(bus.mem_stall), 32'h1);
    end
    chk("t5_err_tied", 32'(bus.dm_err), 32'h0);
    tick();
    mem_resp(1'b1, 32'hCAFE0001);
    #1;
    chk("t5_final_ack_stall", 32'(bus.mem_stall), 32'h0);
    push(1'b1, 2'b01, 5'd9, 32'h50, 32'hCAFE0001, 32'h10C);
    tick();
    nop();
    mem_resp(1'b0, 32'h0);
`endif

    // Back-to-back read then write, each acked one cycle late.
    tick();
    set_instr(32'h110, 32'h60, 32'h0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
    #1;
    chk("t6_rd_stall", 32'(bus.mem_stall), 32'h1);
    tick();
    mem_resp(1'b1, 32'h00001234);
    #1;
    chk("t6_rd_ack_stall", 32'(bus.mem_stall), 32'h0);
    push(1'b1, 2'b01, 5'd10, 32'h60, 32'h00001234, 32'h110);
    tick();
    set_instr(32'h114, 32'h64, 32'h77, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    mem_resp(1'b0, 32'h0);
    #1;
    chk("t6_wr_stall", 32'(bus.mem_stall), 32'h1);
    chk("t6_wr_wdata", bus.dm_wdata, 32'h77);
    tick();
    mem_resp(1'b1, 32'h0);
    #1;
    chk("t6_wr_ack_stall", 32'(bus.mem_stall), 32'h0);
    push(1'b0, 2'b00, 5'd11, 32'h64, 32'h0, 32'h114);

    // Read and write both set: write wins, no read data captured.
    tick();
    set_instr(32'h11C, 32'h80, 32'h99, 5'd13, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    mem_resp(1'b1, 32'h12345678);
    #1;
    chk("t7_we_wins", 32'(bus.dm_we), 32'h1);
    chk("t7_stall", 32'(bus.mem_stall), 32'h0);
    push(1'b0, 2'b00, 5'd13, 32'h80, 32'h0, 32'h11C);
    tick();
    nop();
    mem_resp(1'b0, 32'h0);

    repeat (3) tick();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
`ifdef MEM_TIMEOUT_EN
    chk("err_sticky", 32'(bus.dm_err), 32'h1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
